zeroriscy_sim_periph: RTL and testbench

//  Simulation peripheral that responds on the crossbar's peripheral slave port (ss_*).

---
 rtl/zeroriscy_sim_periph.sv | 243 ++++++++++++++++++++++++
 tb/tb_zeroriscy_sim_periph.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroriscy_sim_periph.sv
// Simulation peripheral on the crossbar's peripheral slave port: tohost/halt register,
// buffered 8N1 UART transmitter and a 64-bit mtime/mtimecmp timer with interrupt.
module zeroriscy_sim_periph #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned BAUD_DIV   = 16,
    parameter int unsigned TIMER_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        p_req,
    input  logic        p_we,
    input  logic [3:0]  p_be,
    input  logic [31:0] p_addr,
    input  logic [31:0] p_wdata,
    output logic [31:0] p_rdata,
    output logic        p_err,
    output logic        uart_tx_o,
    output logic        timer_irq_o,
    output logic        halt_o,
    output logic [31:0] exit_code_o
);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;
    localparam int unsigned BaudW = $clog2(BAUD_DIV);
    localparam int unsigned PreW  = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
    localparam logic [CntW-1:0]  Full     = CntW'(FIFO_DEPTH);
    localparam logic [BaudW-1:0] BaudLast = BaudW'(BAUD_DIV - 1);
    localparam logic [PreW-1:0]  PreLast  = PreW'(TIMER_DIV - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} tx_state_e;

    function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    logic [3:0]      off;
    logic            unused_addr;
    logic            wr, rd;
    logic            wr_tohost, wr_tx, wr_stat, wr_mlo, wr_mhi, wr_clo, wr_chi;
    logic [31:0]     rdata_q, rd_data;
    logic            err_q, rd_err;
    logic [31:0]     tohost_q, tohost_new;
    logic            halt_q;
    logic [31:0]     exit_q;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            fifo_nonempty, push, pop;
    tx_state_e       state_q;
    logic [BaudW-1:0] baud_q;
    logic            baud_last;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            tx_q;
    logic [PreW-1:0] presc_q, presc_d;
    logic            tick;
    logic [63:0]     mtime_q, mtime_d, mtime_inc, mtimecmp_q, cmp_d;

    assign off         = p_addr[5:2];
    assign unused_addr = ^{p_addr[31:6], p_addr[1:0]};
    assign wr          = p_req & p_we;
    assign rd          = p_req & ~p_we;
    assign wr_tohost   = wr && (off == 4'd0);
    assign wr_tx       = wr && (off == 4'd1) && p_be[0];
    assign wr_stat     = wr && (off == 4'd2);
    assign wr_mlo      = wr && (off == 4'd4);
    assign wr_mhi      = wr && (off == 4'd5);
    assign wr_clo      = wr && (off == 4'd6);
    assign wr_chi      = wr && (off == 4'd7);
    assign tohost_new  = be_merge(tohost_q, p_wdata, p_be);

    // FIFO: a push while full is dropped even if a pop happens in the same cycle
    assign fifo_nonempty = (cnt_q != '0);
    assign push          = wr_tx && (cnt_q != Full);
    assign baud_last     = (baud_q == BaudLast);
    assign pop           = fifo_nonempty &&
                           ((state_q == StIdle) || ((state_q == StStop) && baud_last));

    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CntW'(1);
            2'b01:   cnt_d = cnt_q - CntW'(1);
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q;
        if (wr_stat && p_be[1] && p_wdata[9]) ovf_d = 1'b0;
        if (wr_tx && (cnt_q == Full)) ovf_d = 1'b1;
    end

    // A write to one mtime half replaces that half and suppresses the pending increment
    assign tick      = (presc_q == PreLast);
    assign mtime_inc = mtime_q + 64'd1;

    always_comb begin
        presc_d = tick ? '0 : presc_q + PreW'(1);
        mtime_d = tick ? mtime_inc : mtime_q;
        if (wr_mlo) mtime_d = {mtime_q[63:32], be_merge(mtime_q[31:0], p_wdata, p_be)};
        if (wr_mhi) mtime_d = {be_merge(mtime_q[63:32], p_wdata, p_be), mtime_q[31:0]};
        cmp_d = mtimecmp_q;
        if (wr_clo) cmp_d = {mtimecmp_q[63:32], be_merge(mtimecmp_q[31:0], p_wdata, p_be)};
        if (wr_chi) cmp_d = {be_merge(mtimecmp_q[63:32], p_wdata, p_be), mtimecmp_q[31:0]};
    end

    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        case (off)
            4'd0: rd_data = tohost_q;
            4'd1: rd_data = '0;
            4'd2: begin
                rd_data[9]   = ovf_q;
                rd_data[8]   = (state_q != StIdle);
                rd_data[7:0] = 8'(cnt_q);
            end
            4'd4:    rd_data = mtime_q[31:0];
            4'd5:    rd_data = mtime_q[63:32];
            4'd6:    rd_data = mtimecmp_q[31:0];
            4'd7:    rd_data = mtimecmp_q[63:32];
            default: rd_err  = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr_q] <= p_wdata[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q    <= '0;
            err_q      <= 1'b0;
            tohost_q   <= '0;
            halt_q     <= 1'b0;
            exit_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
        end else begin
            if (rd) begin
                rdata_q <= rd_data;
                err_q   <= rd_err;
            end
            if (wr_tohost) begin
                tohost_q <= tohost_new;
                if (tohost_new != '0) begin
                    halt_q <= 1'b1;
                    exit_q <= tohost_new;
                end
            end
            if (push) wptr_q <= wptr_q + PtrW'(1);
            if (pop)  rptr_q <= rptr_q + PtrW'(1);
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= cmp_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    baud_q <= '0;
                    if (pop) begin
                        state_q <= StStart;
                        shift_q <= fifo_mem[rptr_q];
                        tx_q    <= 1'b0;
                    end
                end
                StStart: begin
                    if (baud_last) begin
                        baud_q  <= '0;
                        bit_q   <= '0;
                        state_q <= StData;
                        tx_q    <= shift_q[0];
                        shift_q <= shift_q >> 1;
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                StData: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= StStop;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[0];
                            shift_q <= shift_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                StStop: begin
                    if (baud_last) begin
                        baud_q <= '0;
                        if (pop) begin
                            state_q <= StStart;
                            shift_q <= fifo_mem[rptr_q];
                            tx_q    <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_q <= baud_q + BaudW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign p_rdata     = rdata_q;
    assign p_err       = err_q;
    assign uart_tx_o   = tx_q;
    assign timer_irq_o = (mtime_q >= mtimecmp_q);
    assign halt_o      = halt_q;
    assign exit_code_o = exit_q;

endmodule

// File: tb/tb_zeroriscy_sim_periph.sv
// Directed bench for zeroriscy_sim_periph: register-access vector table plus hand-written
// UART frame, FIFO overflow, timer and tohost sequences.
module tb_zeroriscy_sim_periph;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        p_req = 1'b0;
    logic        p_we = 1'b0;
    logic [3:0]  p_be = 4'h0;
    logic [31:0] p_addr = '0;
    logic [31:0] p_wdata = '0;
    logic [31:0] p_rdata;
    logic        p_err;
    logic        uart_tx_o;
    logic        timer_irq_o;
    logic        halt_o;
    logic [31:0] exit_code_o;

    int n_pass = 0;
    int n_total = 0;

    zeroriscy_sim_periph #(
        .FIFO_DEPTH(2),
        .BAUD_DIV  (4),
        .TIMER_DIV (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .p_req      (p_req),
        .p_we       (p_we),
        .p_be       (p_be),
        .p_addr     (p_addr),
        .p_wdata    (p_wdata),
        .p_rdata    (p_rdata),
        .p_err      (p_err),
        .uart_tx_o  (uart_tx_o),
        .timer_irq_o(timer_irq_o),
        .halt_o     (halt_o),
        .exit_code_o(exit_code_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        p_req = 1'b1; p_we = 1'b1; p_addr = a; p_wdata = d; p_be = be;
        tick();
        p_req = 1'b0; p_we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] rd, output logic er);
        p_req = 1'b1; p_we = 1'b0; p_addr = a; p_be = 4'h0;
        tick();
        p_req = 1'b0;
        rd = p_rdata;
        er = p_err;
    endtask

    // Checks one 40-cycle frame starting at cycle 'skip'; reads STATUS mid-frame.
    task automatic check_frame(input logic [7:0] b, input int skip, input logic [31:0] exp_st);
        logic [9:0]  bits;
        logic [31:0] st;
        int          nbad;
        bits = {1'b1, b, 1'b0};
        nbad = 0;
        st   = 32'hdead_beef;
        for (int t = skip; t < 40; t++) begin
            if (uart_tx_o !== bits[t/4]) nbad++;
            if (t == 20) begin
                p_req = 1'b1; p_we = 1'b0; p_addr = 32'h08;
            end
            tick();
            if (t == 20) begin
                p_req = 1'b0;
                st = p_rdata;
            end
        end
        check("frame_bad_cycles", nbad, 0);
        check("frame_mid_status", st, exp_st);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, last_rd;
        logic        er, last_er;
        int          rise_at;

        vecs[0]  = '{1'b0, 32'h08, 4'h0, 32'h0,          32'h0,          1'b0};
        vecs[1]  = '{1'b0, 32'h0C, 4'h0, 32'h0,          32'h0,          1'b1};
        vecs[2]  = '{1'b1, 32'h18, 4'hF, 32'h1234_5678,  32'h0,          1'b0};
        vecs[3]  = '{1'b0, 32'h18, 4'h0, 32'h0,          32'h1234_5678,  1'b0};
        vecs[4]  = '{1'b1, 32'h18, 4'h5, 32'hAABB_CCDD,  32'h0,          1'b0};
        vecs[5]  = '{1'b0, 32'h18, 4'h0, 32'h0,          32'h12BB_56DD,  1'b0};
        vecs[6]  = '{1'b0, 32'h1C, 4'h0, 32'h0,          32'hFFFF_FFFF,  1'b0};
        vecs[7]  = '{1'b1, 32'h24, 4'hF, 32'h5,          32'h0,          1'b0};
        vecs[8]  = '{1'b0, 32'h24, 4'h0, 32'h0,          32'h0,          1'b1};
        vecs[9]  = '{1'b1, 32'h00, 4'hF, 32'h0,          32'h0,          1'b0};
        vecs[10] = '{1'b0, 32'h00, 4'h0, 32'h0,          32'h0,          1'b0};
        vecs[11] = '{1'b0, 32'h04, 4'h0, 32'h0,          32'h0,          1'b0};
        vecs[12] = '{1'b1, 32'h18, 4'hF, 32'hFFFF_FFFF,  32'h0,          1'b0};
        vecs[13] = '{1'b0, 32'h18, 4'h0, 32'h0,          32'hFFFF_FFFF,  1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_rdata", p_rdata, 0);
        check("rst_err", 32'(p_err), 0);
        check("rst_tx", 32'(uart_tx_o), 1);
        check("rst_irq", 32'(timer_irq_o), 0);
        check("rst_halt", 32'(halt_o), 0);
        check("rst_exit", exit_code_o, 0);

        // Register access table; writes must leave the read port untouched
        last_rd = 32'h0;
        last_er = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].we) begin
                bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
                check("vec_wr_hold_rdata", p_rdata, last_rd);
                check("vec_wr_hold_err", 32'(p_err), 32'(last_er));
            end else begin
                bus_read(vecs[i].addr, rd, er);
                check("vec_rd_data", rd, vecs[i].exp_rd);
                check("vec_rd_err", 32'(er), 32'(vecs[i].exp_err));
                last_rd = rd;
                last_er = er;
            end
        end
        check("vec_halt", 32'(halt_o), 0);

        // mtime write collides with increment; carry into the high half
        bus_write(32'h10, 32'h100, 4'hF);
        bus_read(32'h10, rd, er);
        check("mtime_lo_write_wins", rd, 32'h100);
        bus_write(32'h10, 32'hFFFF_FFFF, 4'hF);
        bus_write(32'h14, 32'h0, 4'hF);
        bus_read(32'h14, rd, er);
        check("mtime_hi_written", rd, 0);
        bus_read(32'h14, rd, er);
        check("mtime_hi_carry", rd, 1);
        bus_read(32'h10, rd, er);
        check("mtime_lo_wrapped", rd, 1);

        // Timer interrupt at mtime == mtimecmp
        bus_write(32'h1C, 32'h1, 4'hF);
        bus_write(32'h18, 32'd10, 4'hF);
        bus_write(32'h14, 32'h0, 4'hF);
        bus_write(32'h10, 32'h0, 4'hF);
        bus_write(32'h1C, 32'h0, 4'hF);
        check("irq_low_at_mtime1", 32'(timer_irq_o), 0);
        rise_at = -1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (timer_irq_o === 1'b1) begin
                rise_at = k;
                break;
            end
        end
        check("irq_rise_cycle", 32'(rise_at), 32'd9);
        bus_read(32'h10, rd, er);
        check("irq_mtime_at_rise", rd, 32'd10);
        check("irq_stays_high", 32'(timer_irq_o), 1);
        bus_write(32'h1C, 32'h1, 4'hF);
        check("irq_drop_cmp_hi", 32'(timer_irq_o), 0);

        // Single UART frame
        bus_write(32'h04, 32'h55, 4'h1);
        check("tx_idle_after_push", 32'(uart_tx_o), 1);
        tick();
        check_frame(8'h55, 0, 32'h100);
        check("tx_idle_after_frame", 32'(uart_tx_o), 1);
        bus_read(32'h08, rd, er);
        check("status_idle", rd, 0);

        // Three back-to-back bytes: contiguous frames, cnt drains per pop
        bus_write(32'h04, 32'hA3, 4'hF);
        bus_write(32'h04, 32'h0F, 4'hF);
        bus_write(32'h04, 32'hC8, 4'hF);
        check_frame(8'hA3, 1, 32'h102);
        check_frame(8'h0F, 0, 32'h101);
        check_frame(8'hC8, 0, 32'h100);
        check("tx_idle_after_burst", 32'(uart_tx_o), 1);
        bus_read(32'h08, rd, er);
        check("status_after_burst", rd, 0);

        // Overflow with a two-entry FIFO, then W1C
        bus_write(32'h04, 32'h11, 4'hF);
        bus_write(32'h04, 32'h22, 4'hF);
        bus_write(32'h04, 32'h33, 4'hF);
        bus_write(32'h04, 32'h44, 4'hF);
        bus_read(32'h08, rd, er);
        check("ovf_status", rd, 32'h302);
        bus_write(32'h08, 32'h200, 4'hF);
        bus_read(32'h08, rd, er);
        check("ovf_cleared", rd, 32'h102);
        rd = 32'hFFFF_FFFF;
        for (int k = 0; k < 300 && rd != 32'h0; k++) bus_read(32'h08, rd, er);
        check("ovf_drain_status", rd, 0);

        // tohost / halt
        bus_write(32'h00, 32'h1, 4'hF);
        check("halt_set", 32'(halt_o), 1);
        check("exit_code_1", exit_code_o, 1);
        bus_write(32'h00, 32'h0, 4'hF);
        check("halt_sticky", 32'(halt_o), 1);
        check("exit_kept_on_zero", exit_code_o, 1);
        bus_read(32'h00, rd, er);
        check("tohost_zero", rd, 0);
        bus_write(32'h00, 32'hDEAD, 4'hF);
        check("exit_code_dead", exit_code_o, 32'hDEAD);
        bus_read(32'h24, rd, er);
        check("unmapped_rdata", rd, 0);
        check("unmapped_err", 32'(er), 1);
        bus_read(32'h08, rd, er);
        check("err_cleared", 32'(er), 0);

        // Reset in the middle of a frame
        bus_write(32'h04, 32'h00, 4'hF);
        bus_write(32'h04, 32'h00, 4'hF);
        repeat (5) tick();
        check("tx_mid_frame_low", 32'(uart_tx_o), 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_tx", 32'(uart_tx_o), 1);
        check("rst_async_halt", 32'(halt_o), 0);
        check("rst_async_exit", exit_code_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        bus_read(32'h08, rd, er);
        check("rst_fifo_lost", rd, 0);
        check("rst_tx_idle", 32'(uart_tx_o), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
